// File: rtl/axi4_master_pkg.sv
// Shared types and constants for the AXI4 burst initiator.
package axi4_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AxSIZE encoding: log2 of the number of bytes in one data beat.
  function automatic logic [2:0] axsize_f(input int data_width);
    int         bytes;
    logic [2:0] sz;
    bytes = data_width / 8;
    sz    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) begin
        sz = 3'(i);
      end
    end
    return sz;
  endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// AXI4 burst initiator: accepts one local read/write command at a time,
// runs the AW/W/B or AR/R handshakes and reports the bus response.
module axi4_burst_master
  import axi4_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // local command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  // local write stream
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  // local read stream
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  rdata_valid,
  output logic                  rdata_last,
  // status
  output logic                  done,
  output logic [1:0]            resp,
  output logic                  protocol_err,
  // write address channel
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // write data channel
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  // write response channel
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // read address channel
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // read data channel
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [2:0] AXSIZE = axsize_f(DATA_WIDTH);
  // Clears the byte-lane bits so every burst starts on a beat boundary.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'((DATA_WIDTH / 8) - 1));

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [1:0]            r_resp;
  logic                  r_done;
  logic                  r_perr;

  logic                  w_accept;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_r_hs;
  logic                  w_cnt_last;

  assign w_cnt_last = (r_cnt == r_len);
  assign w_accept   = (r_state == IDLE) && cmd_valid;
  assign w_w_hs     = (r_state == WR_DATA) && wdata_valid && WREADY;
  assign w_b_hs     = (r_state == WR_RESP) && BVALID;
  assign w_r_hs     = (r_state == RD_DATA) && RVALID;

  // Address/len come straight from the latched command so they stay stable
  // for the whole burst; size is fixed by the data width.
  assign AWADDR    = r_addr;
  assign AWLEN     = r_len;
  assign AWSIZE    = AXSIZE;
  assign ARADDR    = r_addr;
  assign ARLEN     = r_len;
  assign ARSIZE    = AXSIZE;
  assign WDATA     = wdata_in;
  assign rdata_out = RDATA;
  assign done      = r_done;
  assign resp      = r_resp;
  assign protocol_err = r_perr;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    AWVALID     = 1'b0;
    WVALID      = 1'b0;
    WLAST       = 1'b0;
    wdata_ready = 1'b0;
    BREADY      = 1'b0;
    ARVALID     = 1'b0;
    RREADY      = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_next = cmd_write ? WR_ADDR : RD_ADDR;
        end else begin
          w_next = IDLE;
        end
      end
      WR_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) begin
          w_next = WR_DATA;
        end else begin
          w_next = WR_ADDR;
        end
      end
      WR_DATA: begin
        WVALID      = wdata_valid;
        wdata_ready = WREADY;
        WLAST       = w_cnt_last;
        if (w_w_hs && w_cnt_last) begin
          w_next = WR_RESP;
        end else begin
          w_next = WR_DATA;
        end
      end
      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          w_next = IDLE;
        end else begin
          w_next = WR_RESP;
        end
      end
      RD_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) begin
          w_next = RD_DATA;
        end else begin
          w_next = RD_ADDR;
        end
      end
      RD_DATA: begin
        RREADY      = 1'b1;
        rdata_valid = RVALID;
        rdata_last  = RVALID && RLAST;
        if (RVALID && RLAST) begin
          w_next = IDLE;
        end else begin
          w_next = RD_DATA;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Latch the aligned start address and length of an accepted command.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr <= {ADDR_WIDTH{1'b0}};
      r_len  <= 8'd0;
    end else if (w_accept) begin
      r_addr <= cmd_addr & ALIGN_MASK;
      r_len  <= cmd_len;
    end
  end

  // Beat counter; saturates at len on reads so a missing RLAST cannot wrap it.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt <= 8'd0;
    end else if (w_accept) begin
      r_cnt <= 8'd0;
    end else if (w_w_hs) begin
      r_cnt <= w_cnt_last ? 8'd0 : (r_cnt + 8'd1);
    end else if (w_r_hs) begin
      if (RLAST) begin
        r_cnt <= 8'd0;
      end else if (!w_cnt_last) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Response: BRESP for writes, first non-OKAY RRESP of a read burst.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_resp <= RESP_OKAY;
    end else if (w_accept) begin
      r_resp <= RESP_OKAY;
    end else if (w_b_hs) begin
      r_resp <= BRESP;
    end else if (w_r_hs && (r_resp == RESP_OKAY)) begin
      r_resp <= RRESP;
    end
  end

  // One-cycle completion pulse, the cycle after the final bus handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_b_hs || (w_r_hs && RLAST);
    end
  end

  // Sticky protocol-violation flag: early/late RLAST or unexpected BVALID.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_perr <= 1'b0;
    end else if ((w_r_hs && RLAST && !w_cnt_last) ||
                 (w_r_hs && !RLAST && w_cnt_last) ||
                 (BVALID && (r_state != WR_RESP))) begin
      r_perr <= 1'b1;
    end
  end

endmodule

// File: doc/axi4_burst_master.md
# axi4_burst_master

AXI4 memory-mapped burst initiator that drives the existing AXI4 slave. A local command port accepts one read or write burst at a time. The block sequences AW/W/B or AR/R handshakes, passes burst data between local streams and the bus, and reports the bus response plus a protocol-error flag. It sits between test/system logic and `axi4_if`. The bus-side port names match the interface signal names.

## Interface

- ADDR_WIDTH, 16, byte address width
- DATA_WIDTH, 32, data beat width; AxSIZE = log2(DATA_WIDTH/8)
- ACLK  in  1  bus clock; all logic on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits ignored
- cmd_len  in  8  beats minus 1 (AXI LEN encoding)
- wdata_in / wdata_valid / wdata_ready  in / in / out  DATA_WIDTH/1/1  local write stream
- rdata_out / rdata_valid / rdata_last  out  DATA_WIDTH/1/1  local read stream (no backpressure)
- done  out  1  one-cycle pulse at burst completion
- resp  out  2  BRESP or accumulated RRESP, valid with done
- protocol_err  out  1  sticky until reset; set on bus protocol violation
- AWADDR, AWLEN, AWSIZE, AWVALID / AWREADY  out… / in  write address channel
- WDATA, WLAST, WVALID / WREADY  out / in  write data channel
- BRESP, BVALID / BREADY  in / out  write response channel
- ARADDR, ARLEN, ARSIZE, ARVALID / ARREADY  out / in  read address channel
- RDATA, RRESP, RLAST, RVALID / RREADY  in / out  read data channel

## Operation

- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr (aligned), len and direction. Next state is WR_ADDR or RD_ADDR.
- WR_ADDR / RD_ADDR: AxVALID=1 with stable AxADDR/AxLEN/AxSIZE until AxREADY. Then go to WR_DATA / RD_DATA.
- WR_DATA: combinational pass-through.
  - WVALID=wdata_valid, WDATA=wdata_in, wdata_ready=WREADY.
  - An 8-bit beat counter increments on each W handshake.
  - WLAST=1 when counter==len.
  - The last-beat handshake moves to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, resp<=BRESP, done pulse, return to IDLE.
- RD_DATA: RREADY=1.
  - rdata_out=RDATA, rdata_valid=RVALID.
  - rdata_last=RVALID&&RLAST.
  - resp accumulator keeps the first non-OKAY RRESP.
  - On RVALID&&RLAST, done pulse and return to IDLE.
- Protocol checks, each setting protocol_err:
  - RLAST with beat counter≠len.
  - RVALID beat with counter==len but RLAST=0. The burst still waits for RLAST.
  - BVALID outside WR_RESP. It is ignored.
- Out-of-range bursts are not filtered locally. They are issued, and the slave's BRESP/RRESP (2'b10 SLVERR) is forwarded.

## Timing

- Reset values (asynchronous): state IDLE, counter 0, resp 2'b00, protocol_err 0.
  - All bus-side outputs are 0: AxVALID, WVALID, WLAST, BREADY, RREADY and all address/len fields.
  - AxSIZE is the constant.
  - cmd_ready=1, done=0.
- Reset mid-burst: all valids/readies drop in the same instant, no done is issued, and the burst is abandoned.
- Command accept at edge N → AxVALID high in cycle N+1 (registered).
- Write latency with AWREADY/WREADY/BVALID always high and wdata_valid high, len=L:
  - AW handshake in cycle N+1.
  - W beats in cycles N+2..N+2+L.
  - BREADY from cycle N+3+L.
  - done in the cycle after B handshake.
- Read: done is registered, one cycle after the RLAST handshake. cmd_ready returns with IDLE in that same cycle.
- Back-to-back commands: next accept is earliest on the cycle done is high. No overlap of bursts.
- len=0: single beat with WLAST=1 on the first beat.
- len=255: the counter must not wrap before WLAST.
- wdata_valid low mid-burst: WVALID=0, counter holds.

## Structure

- Package axi4_master_pkg holds:
  - the state enum;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - an AxSIZE function of DATA_WIDTH.
- Single module; no sub-module (beat counter and FSM are inline).

## Test plan

- Write addr 0x0010, len 3, data 0xA0..0xA3, slave always ready, BRESP 00:
  - four W beats, WLAST only on 0xA3;
  - AWADDR=0x0010, AWLEN=3;
  - done with resp 00.
- Read addr 0x0040, len 1, slave returns 0x11,0x22 with RLAST on the second beat:
  - rdata_out 0x11 then 0x22;
  - rdata_last on the second beat;
  - resp 00.
- Write with AWREADY delayed 4 cycles and WREADY toggling every cycle:
  - AWVALID/AWADDR stable until the handshake;
  - no beat lost or duplicated;
  - done after BRESP.
- Write from (addr>>2)=1022, len 3, at the slave's depth of 1024 words:
  - burst issued;
  - slave BRESP 10;
  - done with resp 10.
- Read len 3 with RLAST on beat 2: protocol_err=1, and done follows the RLAST beat.
- ARESETn low during the second W beat:
  - WVALID/BREADY immediately 0, no done, cmd_ready=1 after release;
  - a subsequent write completes normally.
